// File: rtl/pipe_run_monitor_pkg.sv
// Shared encodings for the pipeline run monitor: FSM states, fail codes and the
// termination decision record used by pipe_run_monitor.
package pipe_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mon_state_e;

    localparam logic [1:0] FAIL_NONE    = 2'b00;
    localparam logic [1:0] FAIL_TEST    = 2'b01;
    localparam logic [1:0] FAIL_TIMEOUT = 2'b10;
    localparam logic [1:0] FAIL_HANG    = 2'b11;

    localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_1000;

    // Outcome of one RUN cycle's termination check.
    typedef struct packed {
        logic       hit;
        logic       pass;
        logic [1:0] code;
    } term_t;

endpackage

// File: rtl/pipe_run_monitor_if.sv
// Monitored core buses and run-status outputs of pipe_run_monitor.
// Trace signals exist only when PIPE_MON_TRACE_EN is defined.
interface pipe_run_monitor_if #(
    parameter int XLEN    = 32,
    parameter int CYCLE_W = 32
);
    logic               start;
    logic               retire_valid;
    logic [XLEN-1:0]    retire_pc;
    logic               dmem_we;
    logic [XLEN-1:0]    dmem_addr;
    logic [XLEN-1:0]    dmem_wdata;
    logic               running;
    logic               done;
    logic               pass;
    logic [1:0]         fail_code;
    logic [XLEN-1:0]    exit_value;
    logic [CYCLE_W-1:0] cycle_count;
    logic [CYCLE_W-1:0] instret_count;
`ifdef PIPE_MON_TRACE_EN
    logic               trace_rd_en;
    logic [XLEN-1:0]    trace_pc;
    logic               trace_valid;

    modport master (
        output start, retire_valid, retire_pc, dmem_we, dmem_addr, dmem_wdata, trace_rd_en,
        input  running, done, pass, fail_code, exit_value, cycle_count, instret_count,
               trace_pc, trace_valid
    );
    modport slave (
        input  start, retire_valid, retire_pc, dmem_we, dmem_addr, dmem_wdata, trace_rd_en,
        output running, done, pass, fail_code, exit_value, cycle_count, instret_count,
               trace_pc, trace_valid
    );
`else
    modport master (
        output start, retire_valid, retire_pc, dmem_we, dmem_addr, dmem_wdata,
        input  running, done, pass, fail_code, exit_value, cycle_count, instret_count
    );
    modport slave (
        input  start, retire_valid, retire_pc, dmem_we, dmem_addr, dmem_wdata,
        output running, done, pass, fail_code, exit_value, cycle_count, instret_count
    );
`endif
endinterface

// File: rtl/pipe_run_monitor_trace_buf.sv
// Circular buffer of retired PCs: push overwrites the oldest entry when full,
// pop advances the read side, clr empties it.
module pipe_trace_buf #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic [XLEN-1:0]            push_data,
    input  logic                       pop,
    output logic [XLEN-1:0]            rd_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full;
    logic             do_pop;

    assign full   = (cnt_q == CNT_W'(DEPTH));
    assign do_pop = pop && (cnt_q != '0);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clr) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wr_d = wr_q + PTR_W'(1);
            // A push into a full buffer drops the oldest entry.
            if (do_pop || (push && full)) rd_d = rd_q + PTR_W'(1);
            if (push && !do_pop && !full) cnt_d = cnt_q + CNT_W'(1);
            else if (do_pop && !push)     cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= push_data;
    end

    assign rd_data = mem_q[rd_q];
    assign count   = cnt_q;

endmodule

// File: rtl/pipe_run_monitor.sv
// Run controller/monitor for the five-stage core: counts cycles and retirements and ends a run
// on tohost write, timeout or hang. Define PIPE_MON_TRACE_EN to add the retired-PC trace buffer.
module pipe_run_monitor
    import pipe_mon_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              CYCLE_W     = 32,
    parameter int              MAX_CYCLES  = 100000,
    parameter int              HANG_LIMIT  = 1024,
    parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(TOHOST_ADDR_DEFAULT)
`ifdef PIPE_MON_TRACE_EN
    ,
    parameter int              TRACE_DEPTH = 8
`endif
) (
    input logic               clk,
    input logic               rst,
    pipe_run_monitor_if.slave mon
);
    localparam logic [CYCLE_W-1:0] CYC_LAST  = CYCLE_W'(MAX_CYCLES - 1);
    localparam logic [CYCLE_W-1:0] IDLE_LAST = CYCLE_W'(HANG_LIMIT - 1);

    mon_state_e         state_q, state_d;
    logic [CYCLE_W-1:0] cycle_q, cycle_d;
    logic [CYCLE_W-1:0] instret_q, instret_d;
    logic [CYCLE_W-1:0] idle_q, idle_d;
    logic               pass_q, pass_d;
    logic [1:0]         fail_q, fail_d;
    logic [XLEN-1:0]    exit_q, exit_d;

    logic  tohost_hit;
    logic  start_run;
    term_t term;

    function automatic logic [CYCLE_W-1:0] sat_inc(input logic [CYCLE_W-1:0] v);
        return (&v) ? v : v + CYCLE_W'(1);
    endfunction

    assign tohost_hit = mon.dmem_we && (mon.dmem_addr == TOHOST_ADDR);
    assign start_run  = mon.start && ((state_q == IDLE) || (state_q == DONE));

    // Termination priority: tohost, then timeout, then hang.
    always_comb begin
        term = '0;
        if (tohost_hit) begin
            term.hit  = 1'b1;
            term.pass = (mon.dmem_wdata == XLEN'(1));
            term.code = term.pass ? FAIL_NONE : FAIL_TEST;
        end else if (cycle_q == CYC_LAST) begin
            term.hit  = 1'b1;
            term.code = FAIL_TIMEOUT;
        end else if ((idle_q == IDLE_LAST) && !mon.retire_valid) begin
            term.hit  = 1'b1;
            term.code = FAIL_HANG;
        end
    end

    always_comb begin
        state_d   = state_q;
        cycle_d   = cycle_q;
        instret_d = instret_q;
        idle_d    = idle_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        exit_d    = exit_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_run) begin
                    state_d   = RUN;
                    cycle_d   = '0;
                    instret_d = '0;
                    idle_d    = '0;
                    pass_d    = 1'b0;
                    fail_d    = FAIL_NONE;
                    exit_d    = '0;
                end
            end
            RUN: begin
                cycle_d = sat_inc(cycle_q);
                if (mon.retire_valid) begin
                    instret_d = sat_inc(instret_q);
                    idle_d    = '0;
                end else begin
                    idle_d    = sat_inc(idle_q);
                end
                if (term.hit) begin
                    state_d = DONE;
                    pass_d  = term.pass;
                    fail_d  = term.code;
                    if (tohost_hit) exit_d = mon.dmem_wdata >> 1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cycle_q   <= '0;
            instret_q <= '0;
            idle_q    <= '0;
            pass_q    <= 1'b0;
            fail_q    <= FAIL_NONE;
            exit_q    <= '0;
        end else begin
            state_q   <= state_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
            idle_q    <= idle_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            exit_q    <= exit_d;
        end
    end

    assign mon.running       = (state_q == RUN);
    assign mon.done          = (state_q == DONE);
    assign mon.pass          = pass_q;
    assign mon.fail_code     = fail_q;
    assign mon.exit_value    = exit_q;
    assign mon.cycle_count   = cycle_q;
    assign mon.instret_count = instret_q;

`ifdef PIPE_MON_TRACE_EN
    logic [$clog2(TRACE_DEPTH):0] trace_count;
    logic                         trace_push;
    logic                         trace_pop;

    assign trace_push = (state_q == RUN) && mon.retire_valid;
    // Readout is only allowed once the run has finished.
    assign trace_pop  = (state_q == DONE) && mon.trace_rd_en && mon.trace_valid;

    pipe_trace_buf #(
        .XLEN  (XLEN),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_buf (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_run),
        .push      (trace_push),
        .push_data (mon.retire_pc),
        .pop       (trace_pop),
        .rd_data   (mon.trace_pc),
        .count     (trace_count)
    );

    assign mon.trace_valid = (trace_count != '0);
`endif

endmodule

// File: tb/tb_pipe_run_monitor.sv
// Self-checking bench for pipe_run_monitor: directed scenarios plus randomized runs
// scored against a cycle-list reference model.
module tb_pipe_run_monitor;
    localparam int          XLEN   = 32;
    localparam int          CW     = 32;
    localparam int          MAXC   = 200;
    localparam int          HANG   = 16;
    localparam int          TDEPTH = 8;
    localparam int          MAXN   = 256;
    localparam logic [31:0] TOHOST = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_run_monitor_if #(.XLEN(XLEN), .CYCLE_W(CW)) mif ();

    pipe_run_monitor #(
        .XLEN        (XLEN),
        .CYCLE_W     (CW),
        .MAX_CYCLES  (MAXC),
        .HANG_LIMIT  (HANG),
        .TOHOST_ADDR (TOHOST)
`ifdef PIPE_MON_TRACE_EN
        ,
        .TRACE_DEPTH (TDEPTH)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .mon (mif)
    );

    // Per-cycle stimulus of one run, index 0 = first RUN cycle.
    bit          st [MAXN];
    bit          rv [MAXN];
    logic [31:0] pc [MAXN];
    bit          we [MAXN];
    logic [31:0] addr [MAXN];
    logic [31:0] wd [MAXN];

    int          exp_t;
    bit          exp_pass;
    logic [1:0]  exp_fc;
    logic [31:0] exp_exit, exp_cyc, exp_ins;
    logic [31:0] exp_trace [$];

    task automatic drive_idle();
        mif.start = 0; mif.retire_valid = 0; mif.retire_pc = '0;
        mif.dmem_we = 0; mif.dmem_addr = '0; mif.dmem_wdata = '0;
`ifdef PIPE_MON_TRACE_EN
        mif.trace_rd_en = 0;
`endif
    endtask

    task automatic clear_stim();
        for (int i = 0; i < MAXN; i++) begin
            st[i] = 0; rv[i] = 0; pc[i] = i * 4; we[i] = 0; addr[i] = '0; wd[i] = '0;
        end
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic begin_run();
        drive_idle();
        mif.start = 1;
        @(posedge clk); #1;
        mif.start = 0;
    endtask

    // Reference: walk the cycle list applying the run rules directly.
    task automatic model(input int n);
        int gap = 0;
        int retired = 0;
        exp_t = -1; exp_pass = 0; exp_fc = 2'b00; exp_exit = '0; exp_cyc = '0; exp_ins = '0;
        exp_trace.delete();
        for (int i = 0; i < n; i++) begin
            if (rv[i]) begin
                retired++; gap = 0;
                exp_trace.push_back(pc[i]);
                if (exp_trace.size() > TDEPTH) void'(exp_trace.pop_front());
            end else gap++;
            if (we[i] && addr[i] == TOHOST) begin
                exp_pass = (wd[i] == 1); exp_fc = exp_pass ? 2'b00 : 2'b01; exp_exit = wd[i] / 2;
            end else if (i == MAXC - 1) exp_fc = 2'b10;
            else if (gap == HANG) exp_fc = 2'b11;
            else continue;
            exp_t = i; exp_cyc = i + 1; exp_ins = retired;
            break;
        end
    endtask

    task automatic play(input int n, output int done_at);
        done_at = -1;
        for (int i = 0; i < n; i++) begin
            mif.start = st[i]; mif.retire_valid = rv[i]; mif.retire_pc = pc[i];
            mif.dmem_we = we[i]; mif.dmem_addr = addr[i]; mif.dmem_wdata = wd[i];
            @(posedge clk); #1;
            if (mif.done) begin done_at = i; break; end
        end
        drive_idle();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (mif.running !== 1'b0) begin errors++; $display("FAIL reset running: got %0b want 0", mif.running); end
        checks++; if (mif.done !== 1'b0) begin errors++; $display("FAIL reset done: got %0b want 0", mif.done); end
        checks++; if (mif.pass !== 1'b0) begin errors++; $display("FAIL reset pass: got %0b want 0", mif.pass); end
        checks++; if (mif.fail_code !== 2'b00) begin errors++; $display("FAIL reset fail_code: got %0b want 00", mif.fail_code); end
        checks++; if (mif.exit_value !== '0) begin errors++; $display("FAIL reset exit_value: got %0h want 0", mif.exit_value); end
        checks++; if (mif.cycle_count !== '0) begin errors++; $display("FAIL reset cycle_count: got %0d want 0", mif.cycle_count); end
        checks++; if (mif.instret_count !== '0) begin errors++; $display("FAIL reset instret_count: got %0d want 0", mif.instret_count); end
`ifdef PIPE_MON_TRACE_EN
        checks++; if (mif.trace_valid !== 1'b0) begin errors++; $display("FAIL reset trace_valid: got %0b want 0", mif.trace_valid); end
`endif
        rst = 0;
        // Activity without start must leave the monitor idle.
        mif.retire_valid = 1; mif.dmem_we = 1; mif.dmem_addr = TOHOST; mif.dmem_wdata = 32'd1;
        repeat (3) @(posedge clk);
        #1 drive_idle();
        checks++; if (mif.running !== 1'b0 || mif.done !== 1'b0) begin errors++; $display("FAIL idle_ignore state: got running=%0b done=%0b want 0/0", mif.running, mif.done); end
        checks++; if (mif.cycle_count !== '0 || mif.instret_count !== '0) begin errors++; $display("FAIL idle_ignore counts: got %0d/%0d want 0/0", mif.cycle_count, mif.instret_count); end
    endtask

    task automatic test_tohost_pass();
        int d;
        do_reset(); clear_stim();
        for (int i = 0; i <= 50; i++) rv[i] = 1;
        st[25] = 1;
        we[50] = 1; addr[50] = TOHOST; wd[50] = 32'd1;
        begin_run();
        checks++; if (mif.running !== 1'b1 || mif.cycle_count !== '0) begin errors++; $display("FAIL pass start: got running=%0b cycle=%0d want 1/0", mif.running, mif.cycle_count); end
        play(60, d);
        checks++; if (d !== 50) begin errors++; $display("FAIL pass done_cycle: got %0d want 50", d); end
        checks++; if (mif.done !== 1'b1 || mif.running !== 1'b0) begin errors++; $display("FAIL pass done/running: got %0b/%0b want 1/0", mif.done, mif.running); end
        checks++; if (mif.pass !== 1'b1 || mif.fail_code !== 2'b00) begin errors++; $display("FAIL pass pass/code: got %0b/%0b want 1/00", mif.pass, mif.fail_code); end
        checks++; if (mif.instret_count !== 32'd51) begin errors++; $display("FAIL pass instret: got %0d want 51", mif.instret_count); end
        checks++; if (mif.cycle_count !== 32'd51) begin errors++; $display("FAIL pass cycle: got %0d want 51", mif.cycle_count); end
    endtask

    task automatic test_tohost_fail_and_hold();
        int d;
        logic [31:0] c0, i0;
        do_reset(); clear_stim();
        for (int i = 0; i < 20; i++) rv[i] = i[0];
        we[20] = 1; addr[20] = TOHOST; wd[20] = 32'h7;
        begin_run(); play(40, d);
        checks++; if (d !== 20) begin errors++; $display("FAIL tfail done_cycle: got %0d want 20", d); end
        checks++; if (mif.pass !== 1'b0 || mif.fail_code !== 2'b01) begin errors++; $display("FAIL tfail pass/code: got %0b/%0b want 0/01", mif.pass, mif.fail_code); end
        checks++; if (mif.exit_value !== 32'd3) begin errors++; $display("FAIL tfail exit_value: got %0h want 3", mif.exit_value); end
        checks++; if (mif.instret_count !== 32'd10) begin errors++; $display("FAIL tfail instret: got %0d want 10", mif.instret_count); end
        c0 = mif.cycle_count; i0 = mif.instret_count;
        // DONE ignores monitored inputs.
        mif.retire_valid = 1; mif.dmem_we = 1; mif.dmem_addr = TOHOST; mif.dmem_wdata = 32'd1;
        repeat (5) @(posedge clk);
        #1 drive_idle();
        checks++; if (mif.done !== 1'b1 || mif.cycle_count !== 32'd21 || mif.instret_count !== 32'd10) begin errors++; $display("FAIL hold counters: got done=%0b %0d/%0d want 1 %0d/%0d", mif.done, mif.cycle_count, mif.instret_count, c0, i0); end
        checks++; if (mif.pass !== 1'b0 || mif.fail_code !== 2'b01 || mif.exit_value !== 32'd3) begin errors++; $display("FAIL hold result: got %0b/%0b/%0h want 0/01/3", mif.pass, mif.fail_code, mif.exit_value); end
        begin_run();
        checks++; if (mif.running !== 1'b1 || mif.done !== 1'b0 || mif.cycle_count !== '0 || mif.instret_count !== '0) begin errors++; $display("FAIL restart clear: got run=%0b done=%0b %0d/%0d want 1 0 0/0", mif.running, mif.done, mif.cycle_count, mif.instret_count); end
        checks++; if (mif.fail_code !== 2'b00 || mif.exit_value !== '0) begin errors++; $display("FAIL restart result: got %0b/%0h want 00/0", mif.fail_code, mif.exit_value); end
        clear_stim();
        for (int i = 0; i <= 5; i++) rv[i] = 1;
        we[5] = 1; addr[5] = TOHOST; wd[5] = 32'd1;
        play(10, d);
        checks++; if (d !== 5 || mif.instret_count !== 32'd6 || mif.pass !== 1'b1) begin errors++; $display("FAIL restart run: got d=%0d instret=%0d pass=%0b want 5/6/1", d, mif.instret_count, mif.pass); end
    endtask

    task automatic test_timeout();
        int d;
        do_reset(); clear_stim();
        for (int i = 0; i < 220; i++) rv[i] = 1;
        we[100] = 1; addr[100] = TOHOST + 32'd4; wd[100] = 32'd1;
        begin_run(); play(220, d);
        checks++; if (d !== MAXC - 1) begin errors++; $display("FAIL timeout done_cycle: got %0d want %0d", d, MAXC - 1); end
        checks++; if (mif.fail_code !== 2'b10 || mif.pass !== 1'b0) begin errors++; $display("FAIL timeout code: got %0b/%0b want 10/0", mif.fail_code, mif.pass); end
        checks++; if (mif.cycle_count !== 32'd200 || mif.instret_count !== 32'd200) begin errors++; $display("FAIL timeout counts: got %0d/%0d want 200/200", mif.cycle_count, mif.instret_count); end
    endtask

    task automatic test_hang();
        int d;
        do_reset(); clear_stim();
        for (int i = 0; i < 10; i++) rv[i] = 1;
        we[12] = 1; addr[12] = 32'h0000_2001; wd[12] = 32'd1;
        begin_run(); play(60, d);
        checks++; if (d !== 25) begin errors++; $display("FAIL hang done_cycle: got %0d want 25", d); end
        checks++; if (mif.fail_code !== 2'b11 || mif.cycle_count !== 32'd26 || mif.instret_count !== 32'd10) begin errors++; $display("FAIL hang result: got %0b %0d/%0d want 11 26/10", mif.fail_code, mif.cycle_count, mif.instret_count); end
    endtask

    task automatic test_priority();
        int d;
        // tohost (wdata 5) on the timeout cycle
        do_reset(); clear_stim();
        for (int i = 0; i < 220; i++) rv[i] = 1;
        we[199] = 1; addr[199] = TOHOST; wd[199] = 32'd5;
        begin_run(); play(220, d);
        checks++; if (d !== 199 || mif.fail_code !== 2'b01 || mif.exit_value !== 32'd2) begin errors++; $display("FAIL prio tohost>timeout: got d=%0d code=%0b exit=%0h want 199/01/2", d, mif.fail_code, mif.exit_value); end
        // tohost pass on the hang cycle
        do_reset(); clear_stim();
        we[15] = 1; addr[15] = TOHOST; wd[15] = 32'd1;
        begin_run(); play(40, d);
        checks++; if (d !== 15 || mif.fail_code !== 2'b00 || mif.pass !== 1'b1) begin errors++; $display("FAIL prio tohost>hang: got d=%0d code=%0b pass=%0b want 15/00/1", d, mif.fail_code, mif.pass); end
        // hang and timeout on the same cycle
        do_reset(); clear_stim();
        for (int i = 0; i < 184; i++) rv[i] = 1;
        begin_run(); play(220, d);
        checks++; if (d !== 199 || mif.fail_code !== 2'b10) begin errors++; $display("FAIL prio timeout>hang: got d=%0d code=%0b want 199/10", d, mif.fail_code); end
    endtask

    task automatic test_reset_midrun();
        int d;
        do_reset(); clear_stim();
        we[3] = 1; addr[3] = TOHOST; wd[3] = 32'h7;
        begin_run(); play(10, d);
        #3 rst = 1;
        #1;
        checks++; if (mif.done !== 1'b0 || mif.fail_code !== 2'b00 || mif.exit_value !== '0 || mif.cycle_count !== '0) begin errors++; $display("FAIL async_rst done: got done=%0b code=%0b exit=%0h cyc=%0d want all 0", mif.done, mif.fail_code, mif.exit_value, mif.cycle_count); end
        #2 rst = 0;
        @(posedge clk); #1;
        clear_stim();
        for (int i = 0; i < 10; i++) rv[i] = 1;
        begin_run(); play(10, d);
        checks++; if (d !== -1 || mif.cycle_count !== 32'd10) begin errors++; $display("FAIL midrun pre: got d=%0d cyc=%0d want -1/10", d, mif.cycle_count); end
        #3 rst = 1;
        #1;
        checks++; if (mif.running !== 1'b0 || mif.cycle_count !== '0 || mif.instret_count !== '0) begin errors++; $display("FAIL async_rst run: got run=%0b %0d/%0d want 0 0/0", mif.running, mif.cycle_count, mif.instret_count); end
`ifdef PIPE_MON_TRACE_EN
        checks++; if (mif.trace_valid !== 1'b0) begin errors++; $display("FAIL async_rst trace_valid: got %0b want 0", mif.trace_valid); end
`endif
        #2 rst = 0;
        @(posedge clk); #1;
        begin_run(); play(3, d);
        checks++; if (mif.cycle_count !== 32'd3 || mif.instret_count !== 32'd3) begin errors++; $display("FAIL rst restart: got %0d/%0d want 3/3", mif.cycle_count, mif.instret_count); end
    endtask

    task automatic test_random();
        int d, mode, k, g;
        for (int s = 0; s < 20; s++) begin
            do_reset(); clear_stim();
            mode = $urandom_range(0, 2);
            k = $urandom_range(0, 190);
            g = $urandom_range(5, 150);
            for (int i = 0; i < 220; i++) begin
                st[i] = ($urandom_range(0, 31) == 0);
                rv[i] = (mode == 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) != 0);
                pc[i] = $urandom & 32'hFFFF_FFFC;
                we[i] = ($urandom_range(0, 3) == 0);
                addr[i] = ($urandom_range(0, 7) == 0) ? TOHOST : ($urandom | 32'h1);
                wd[i] = $urandom_range(0, 1) ? 32'd1 : $urandom;
                if (mode != 0 && addr[i] == TOHOST) we[i] = 0;
                if (mode == 2 && i >= g) rv[i] = 0;
            end
            if (mode == 0) begin we[k] = 1; addr[k] = TOHOST; end
            model(220);
            begin_run(); play(220, d);
            checks++; if (d !== exp_t) begin errors++; $display("FAIL rand%0d done_cycle: got %0d want %0d", s, d, exp_t); end
            checks++; if (mif.pass !== exp_pass || mif.fail_code !== exp_fc || mif.exit_value !== exp_exit) begin errors++; $display("FAIL rand%0d result: got %0b/%0b/%0h want %0b/%0b/%0h", s, mif.pass, mif.fail_code, mif.exit_value, exp_pass, exp_fc, exp_exit); end
            checks++; if (mif.cycle_count !== exp_cyc || mif.instret_count !== exp_ins) begin errors++; $display("FAIL rand%0d counts: got %0d/%0d want %0d/%0d", s, mif.cycle_count, mif.instret_count, exp_cyc, exp_ins); end
        end
    endtask

`ifdef PIPE_MON_TRACE_EN
    task automatic test_trace();
        int d;
        do_reset(); clear_stim();
        for (int i = 0; i < 12; i++) rv[i] = 1;
        we[12] = 1; addr[12] = TOHOST; wd[12] = 32'd1;
        model(20);
        begin_run();
        mif.trace_rd_en = 1;
        play(20, d);
        checks++; if (d !== 12 || mif.pass !== 1'b1) begin errors++; $display("FAIL trace run: got d=%0d pass=%0b want 12/1", d, mif.pass); end
        for (int j = 0; j < 8; j++) begin
            checks++; if (mif.trace_valid !== 1'b1 || mif.trace_pc !== 32'h10 + 32'(j * 4)) begin errors++; $display("FAIL trace pop%0d: got v=%0b pc=%0h want 1/%0h", j, mif.trace_valid, mif.trace_pc, 32'h10 + 32'(j * 4)); end
            mif.trace_rd_en = 1;
            @(posedge clk); #1;
            mif.trace_rd_en = 0;
        end
        mif.trace_rd_en = 1;
        @(posedge clk); #1;
        mif.trace_rd_en = 0;
        checks++; if (mif.trace_valid !== 1'b0) begin errors++; $display("FAIL trace empty: got %0b want 0", mif.trace_valid); end
        checks++; if (exp_trace.size() !== 8) begin errors++; $display("FAIL trace model depth: got %0d want 8", exp_trace.size()); end
    endtask
`endif

    initial begin
        drive_idle();
        test_reset();
        test_tohost_pass();
        test_tohost_fail_and_hold();
        test_timeout();
        test_hang();
        test_priority();
        test_reset_midrun();
        test_random();
`ifdef PIPE_MON_TRACE_EN
        test_trace();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
